// File: rtl/iomem_timer.sv
// Countdown timer target on the iomem bus: prescaler, 32-bit down-counter with
// one-shot or auto-reload, sticky expiry flag and a level interrupt.
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int unsigned PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    localparam logic [2:0] RegCtrl   = 3'd0;
    localparam logic [2:0] RegPresc  = 3'd1;
    localparam logic [2:0] RegLoad   = 3'd2;
    localparam logic [2:0] RegCount  = 3'd3;
    localparam logic [2:0] RegStatus = 3'd4;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

    logic               ready_q, ready_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        load_q, load_d;
    logic [31:0]        count_q, count_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic               expired_q, expired_d;

    logic        hit, sel, wr, tick, expire, w1c;
    logic [2:0]  reg_idx;
    logic [31:0] presc_ext, rd_val;
    logic        addr_unused;

    assign hit       = iomem_addr[31:5] == BASE_ADDR[31:5];
    // Blocking on ready_q guarantees a gap cycle between responses.
    assign sel       = iomem_valid & hit & ~ready_q;
    assign wr        = sel & (|iomem_wstrb);
    assign reg_idx   = iomem_addr[4:2];
    assign presc_ext = 32'(presc_q);
    assign addr_unused = ^iomem_addr[1:0];

    assign tick   = ctrl_q[0] & (pcnt_q == '0);
    assign expire = tick & (count_q == '0);
    assign w1c    = wr & (reg_idx == RegStatus) & iomem_wstrb[0] & iomem_wdata[0];

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            RegCtrl:   rd_val = {29'b0, ctrl_q};
            RegPresc:  rd_val = presc_ext;
            RegLoad:   rd_val = load_q;
            RegCount:  rd_val = count_q;
            RegStatus: rd_val = {31'b0, expired_q};
            default:   rd_val = '0;
        endcase
    end

    always_comb begin
        ready_d   = sel;
        rdata_d   = sel ? rd_val : 32'h0;
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        load_d    = load_q;
        count_d   = count_q;
        pcnt_d    = pcnt_q;
        // Expiry set wins over a coincident write-1-to-clear.
        expired_d = expire | (expired_q & ~w1c);

        if (ctrl_q[0]) begin
            pcnt_d = tick ? presc_q : pcnt_q - PRESC_W'(1);
        end
        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 32'd1;
            end else if (ctrl_q[1]) begin
                count_d = load_q;
            end else begin
                ctrl_d[0] = 1'b0;
            end
        end

        // Bus writes are applied last so they override timer updates.
        if (wr) begin
            case (reg_idx)
                RegCtrl: begin
                    if (iomem_wstrb[0]) begin
                        ctrl_d = iomem_wdata[2:0];
                        if (iomem_wdata[0] && !ctrl_q[0]) pcnt_d = presc_q;
                    end
                end
                RegPresc: presc_d = PRESC_W'(merge_bytes(presc_ext, iomem_wdata, iomem_wstrb));
                RegLoad:  load_d  = merge_bytes(load_q, iomem_wdata, iomem_wstrb);
                RegCount: count_d = merge_bytes(count_q, iomem_wdata, iomem_wstrb);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            presc_q   <= '0;
            load_q    <= '0;
            count_q   <= '0;
            pcnt_q    <= '0;
            expired_q <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            load_q    <= load_d;
            count_q   <= count_d;
            pcnt_q    <= pcnt_d;
            expired_q <= expired_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = expired_q & ctrl_q[2];

endmodule
